mem_port_arbiter: RTL

- Shares the single external memory port (address, write data, dm_ctrl, write enable, MIO_ready handshake) between two requesters: instruction fetch (IF, read-only) and the data-access stage (D, load/store).
- Sits between the pipelined CPU core and the memory/IO bus.
- Per-requester stall signals let the pipeline freeze while its access is outstanding.
- Data access has priority, with a one-shot fairness rule so fetch cannot be starved.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_arb_timer.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Purpose : shared encodings for the memory port arbiter.
//           - arb_state_t : arbiter FSM state (IDLE / fetch busy / data busy)
//           - DM_WORD     : access code driven on the bus for instruction fetch
//           - pick_d      : data-vs-fetch arbitration decision
// Ports   : none (package)
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_IF   = 2'b01,
        ARB_D    = 2'b10
    } arb_state_t;

    localparam logic [2:0] DM_WORD = 3'b000;

    // D wins unless fetch is also waiting and D was the last one served.
    function automatic logic pick_d(input logic d_elig,
                                    input logic if_elig,
                                    input logic last_d);
        return d_elig & (~if_elig | ~last_d);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// ---------------------------------------------------------------------------
// mem_arb_timer
// Purpose : bus-wait timeout counter for the memory port arbiter.
//           Loaded on i_clear, counts down once per enabled cycle and
//           reports o_expired when the terminal count (zero) is reached.
//           The load value is TIMEOUT_CYCLES-1 so that o_expired is seen
//           before the TIMEOUT_CYCLES-th waiting edge, which lets the
//           arbiter abort on exactly that edge.
// Ports   : i_clk      clock
//           i_reset    asynchronous active-low reset
//           i_clear    reload the counter (transaction start)
//           i_en       count one wait cycle
//           o_expired  terminal count reached
// ---------------------------------------------------------------------------
module mem_arb_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= LOAD_VAL;
        end else if (i_clear) begin
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Purpose : shares one external memory port between instruction fetch (IF,
//           read-only) and the data stage (D, load/store). D has priority,
//           but after D has been served a waiting fetch goes next, so fetch
//           cannot be starved. All outputs except the stalls are registered.
//
// Optional: MEM_TIMEOUT_EN - when defined, a transaction that waits
//           TIMEOUT_CYCLES cycles for i_bus_ready is aborted: the owner gets
//           its ack, o_rdata is zeroed and o_bus_err pulses. When undefined
//           the arbiter waits indefinitely and o_bus_err stays 0.
//
// Ports   : i_clk          clock, rising edge
//           i_reset        asynchronous active-low reset
//           i_if_req/addr  fetch request and address (held until ack)
//           o_if_ack       one-cycle fetch completion pulse
//           o_if_stall     i_if_req & ~o_if_ack
//           i_d_req/addr/wdata/we/dm_ctrl  data request (held until ack)
//           o_d_ack        one-cycle data completion pulse
//           o_d_stall      i_d_req & ~o_d_ack
//           o_rdata        read data, valid with the matching ack
//           o_bus_req/addr/wdata/we/dm_ctrl  registered bus transaction
//           i_bus_ready    completes the transaction while o_bus_req is high
//           i_bus_rdata    bus read data, sampled on the completing edge
//           o_bus_err      one-cycle pulse on timeout abort
//
// State table:
//   ARB_IDLE | bus free, arbitrate eligible requesters
//   ARB_IF   | fetch transaction on the bus, waiting for i_bus_ready
//   ARB_D    | data transaction on the bus, waiting for i_bus_ready
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic              o_if_stall,

    input  logic              i_d_req,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    input  logic              i_d_we,
    input  logic [2:0]        i_d_dm_ctrl,
    output logic              o_d_ack,
    output logic              o_d_stall,

    output logic [DATA_W-1:0] o_rdata,

    output logic              o_bus_req,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    output logic              o_bus_we,
    output logic [2:0]        o_bus_dm_ctrl,
    input  logic              i_bus_ready,
    input  logic [DATA_W-1:0] i_bus_rdata,
    output logic              o_bus_err
);

    arb_state_t        r_state;
    logic              r_last_d;
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_rdata;
    logic              r_bus_req;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic              r_bus_we;
    logic [2:0]        r_bus_dm_ctrl;
    logic              r_bus_err;

    logic w_if_elig;
    logic w_d_elig;
    logic w_grant;
    logic w_busy;
    logic w_timeout;
    logic w_done;

    // A requester whose ack is high this cycle has already been served and
    // must not be granted again on its stale request.
    assign w_if_elig = i_if_req & ~r_if_ack;
    assign w_d_elig  = i_d_req  & ~r_d_ack;
    assign w_busy    = (r_state != ARB_IDLE);
    assign w_grant   = (r_state == ARB_IDLE) & (w_if_elig | w_d_elig);

`ifdef MEM_TIMEOUT_EN
    logic w_tmr_expired;

    mem_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_grant),
        .i_en      (w_busy & ~i_bus_ready),
        .o_expired (w_tmr_expired)
    );

    // i_bus_ready on the timeout edge takes precedence (normal completion).
    assign w_timeout = w_busy & ~i_bus_ready & w_tmr_expired;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout            = 1'b0;
`endif

    assign w_done = i_bus_ready | w_timeout;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ARB_IDLE;
            r_last_d      <= 1'b0;
            r_if_ack      <= 1'b0;
            r_d_ack       <= 1'b0;
            r_rdata       <= '0;
            r_bus_req     <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_bus_we      <= 1'b0;
            r_bus_dm_ctrl <= 3'b000;
            r_bus_err     <= 1'b0;
        end else begin
            // acks and the error flag are single-cycle pulses
            r_if_ack  <= 1'b0;
            r_d_ack   <= 1'b0;
            r_bus_err <= 1'b0;

            case (r_state)
                ARB_IDLE: begin
                    if (pick_d(w_d_elig, w_if_elig, r_last_d)) begin
                        r_bus_req     <= 1'b1;
                        r_bus_addr    <= i_d_addr;
                        r_bus_wdata   <= i_d_wdata;
                        r_bus_we      <= i_d_we;
                        r_bus_dm_ctrl <= i_d_dm_ctrl;
                        r_state       <= ARB_D;
                    end else if (w_if_elig) begin
                        r_bus_req     <= 1'b1;
                        r_bus_addr    <= i_if_addr;
                        r_bus_wdata   <= '0;
                        r_bus_we      <= 1'b0;
                        r_bus_dm_ctrl <= DM_WORD;
                        r_state       <= ARB_IF;
                    end
                end

                ARB_IF, ARB_D: begin
                    if (w_done) begin
                        r_bus_req <= 1'b0;
                        r_rdata   <= i_bus_ready ? i_bus_rdata : '0;
                        r_bus_err <= ~i_bus_ready;
                        if (r_state == ARB_D) begin
                            r_d_ack  <= 1'b1;
                            r_last_d <= 1'b1;
                        end else begin
                            r_if_ack <= 1'b1;
                            r_last_d <= 1'b0;
                        end
                        r_state <= ARB_IDLE;
                    end
                end

                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_if_ack      = r_if_ack;
    assign o_d_ack       = r_d_ack;
    assign o_if_stall    = i_if_req & ~r_if_ack;
    assign o_d_stall     = i_d_req  & ~r_d_ack;
    assign o_rdata       = r_rdata;
    assign o_bus_req     = r_bus_req;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wdata   = r_bus_wdata;
    assign o_bus_we      = r_bus_we;
    assign o_bus_dm_ctrl = r_bus_dm_ctrl;
    assign o_bus_err     = r_bus_err;

endmodule
